// File: rtl/aux_ctrl_pkg.sv
// Shared definitions for the aux CPLD select-register sequencer:
// select-word layout, sequencer state encoding and word-source tag.
package aux_ctrl_pkg;

    localparam int SEL_W    = 8;
    localparam int LAB_LSB  = 0;
    localparam int LAB_W    = 4;
    localparam int ASEL_LSB = 4;
    localparam int ASEL_W   = 3;
    localparam int BIST_BIT = 7;

    localparam logic [ASEL_W-1:0] ANALOG_PASSTHROUGH = 3'b100;

    // Sequencer states; the SHIFT_LO/SHIFT_HI phases live inside the serializer.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [1:0] ST_DWELL = 2'd3;

    typedef enum logic {
        SRC_HOST = 1'b0,
        SRC_SCAN = 1'b1
    } word_src_e;

    function automatic logic [SEL_W-1:0] make_sel(input logic bist,
                                                  input logic [ASEL_W-1:0] asel,
                                                  input logic [LAB_W-1:0] lab);
        logic [SEL_W-1:0] w;
        w                        = '0;
        w[LAB_LSB +: LAB_W]      = lab;
        w[ASEL_LSB +: ASEL_W]    = asel;
        w[BIST_BIT]              = bist;
        return w;
    endfunction

endpackage

// File: rtl/aux_ctrl_sequencer_if.sv
// Host write handshake into the aux CPLD select sequencer.
interface aux_ctrl_sequencer_if;

    logic       wr_valid_i;
    logic [7:0] wr_data_i;
    logic       wr_ready_o;

    modport master (output wr_valid_i, output wr_data_i, input wr_ready_o);
    modport slave  (input wr_valid_i, input wr_data_i, output wr_ready_o);

endinterface

// File: rtl/aux_ctrl_serializer.sv
// 8-bit LSB-first shifter driving CTRL_CLK/CTRL_DATA with a CLKDIV-cycle
// half-period; start loads a word, done marks the last high-phase cycle.
module aux_ctrl_serializer #(
    parameter int CLKDIV = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       start,
    input  logic [7:0] word,
    output logic       ctrl_clk,
    output logic       ctrl_data,
    output logic       done
);

    localparam int TW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

    logic          active;
    logic          phase_hi;
    logic [2:0]    bit_idx;
    logic [TW-1:0] timer;
    logic [7:0]    shreg;
    logic          half_end;

    assign half_end  = (timer == TW'(CLKDIV - 1));
    assign done      = active && phase_hi && half_end && (bit_idx == 3'd7);
    assign ctrl_clk  = phase_hi;
    assign ctrl_data = shreg[0];

    // NOTE: every flop here is async-reset so CTRL_CLK drops the moment RST_N asserts.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            active   <= 1'b0;
            phase_hi <= 1'b0;
            bit_idx  <= '0;
            timer    <= '0;
            shreg    <= '0;
        end else if (start) begin
            active   <= 1'b1;
            phase_hi <= 1'b0;
            bit_idx  <= '0;
            timer    <= '0;
            shreg    <= word;
        end else if (active) begin
            if (!half_end) begin
                timer <= timer + TW'(1);
            end else begin
                timer <= '0;
                if (!phase_hi) begin
                    phase_hi <= 1'b1;
                end else begin
                    phase_hi <= 1'b0;
                    // Data only moves at the end of a high phase, so it is stable while CTRL_CLK is high.
                    if (bit_idx == 3'd7) begin
                        active <= 1'b0;
                        shreg  <= '0;
                    end else begin
                        bit_idx <= bit_idx + 3'd1;
                        shreg   <= shreg >> 1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/aux_ctrl_sequencer.sv
// Arbitrates host writes and the autonomous MONTIMING LAB scan onto the CPLD
// select shift register, and keeps a shadow of the word the CPLD holds.
module aux_ctrl_sequencer
    import aux_ctrl_pkg::*;
#(
    parameter int CLKDIV  = 4,
    parameter int DWELL_W = 16,
    parameter int NUM_LAB = 12
) (
    input  logic               CLK,
    input  logic               RST_N,
    aux_ctrl_sequencer_if.slave host,
    input  logic               scan_en_i,
    input  logic [DWELL_W-1:0] dwell_i,
    output logic               CTRL_CLK,
    output logic               CTRL_DATA,
    output logic               busy_o,
    output logic [7:0]         cur_sel_o,
    output logic               scan_wrap_o
);

    logic [1:0]         state;
    word_src_e          src;
    logic [3:0]         scan_idx;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [7:0]         word_q;
    logic [7:0]         start_word;
    logic               ser_start;
    logic               ser_done;

    // IDLE is only ever entered with the dwell counter at zero, so scan may go at once.
    assign ser_start       = (state == ST_IDLE) && (host.wr_valid_i || scan_en_i);
    assign host.wr_ready_o = (state == ST_IDLE) && host.wr_valid_i;
    assign start_word      = host.wr_valid_i ? host.wr_data_i
                                             : make_sel(1'b0, '0, scan_idx);
    assign busy_o          = (state == ST_SHIFT) || (state == ST_DONE);

    aux_ctrl_serializer #(.CLKDIV(CLKDIV)) u_ser (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .start     (ser_start),
        .word      (start_word),
        .ctrl_clk  (CTRL_CLK),
        .ctrl_data (CTRL_DATA),
        .done      (ser_done)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= ST_IDLE;
            src         <= SRC_HOST;
            scan_idx    <= '0;
            dwell_cnt   <= '0;
            word_q      <= '0;
            cur_sel_o   <= '0;
            scan_wrap_o <= 1'b0;
        end else begin
            scan_wrap_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ser_start) begin
                        state  <= ST_SHIFT;
                        word_q <= start_word;
                        src    <= host.wr_valid_i ? SRC_HOST : SRC_SCAN;
                    end
                end
                ST_SHIFT: begin
                    if (ser_done) state <= ST_DONE;
                end
                ST_DONE: begin
                    cur_sel_o <= word_q;
                    state     <= ST_IDLE;
                    if (src == SRC_SCAN) begin
                        if (scan_idx == 4'(NUM_LAB - 1)) begin
                            scan_idx    <= '0;
                            scan_wrap_o <= 1'b1;
                        end else begin
                            scan_idx <= scan_idx + 4'd1;
                        end
                        // A zero dwell skips DWELL entirely: one IDLE cycle between scan words.
                        if (scan_en_i && (dwell_i != '0)) begin
                            dwell_cnt <= dwell_i;
                            state     <= ST_DWELL;
                        end
                    end
                end
                ST_DWELL: begin
                    if (host.wr_valid_i || !scan_en_i || (dwell_cnt == DWELL_W'(1))) begin
                        dwell_cnt <= '0;
                        state     <= ST_IDLE;
                    end else begin
                        dwell_cnt <= dwell_cnt - DWELL_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aux_ctrl_sequencer.sv
// Scoreboard bench for aux_ctrl_sequencer: stimulus pushes expected words,
// a serial-link monitor reassembles each word and checks it on completion.
module tb_aux_ctrl_sequencer;

    localparam int CLKDIV   = 2;
    localparam int DWELL_W  = 16;
    localparam int NUM_LAB  = 12;
    localparam int BUSY_LEN = 16 * CLKDIV + 1;
    localparam int BASE_GAP = 16 * CLKDIV + 2;

    logic               CLK = 1'b0;
    logic               RST_N = 1'b0;
    logic               scan_en_i = 1'b0;
    logic [DWELL_W-1:0] dwell_i = '0;
    logic               CTRL_CLK, CTRL_DATA, busy_o, scan_wrap_o;
    logic [7:0]         cur_sel_o;

    aux_ctrl_sequencer_if host_if ();

    aux_ctrl_sequencer #(.CLKDIV(CLKDIV), .DWELL_W(DWELL_W), .NUM_LAB(NUM_LAB)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .host        (host_if.slave),
        .scan_en_i   (scan_en_i),
        .dwell_i     (dwell_i),
        .CTRL_CLK    (CTRL_CLK),
        .CTRL_DATA   (CTRL_DATA),
        .busy_o      (busy_o),
        .cur_sel_o   (cur_sel_o),
        .scan_wrap_o (scan_wrap_o)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] word;
        int         gap;   // expected start-to-start spacing, -1 when unconstrained
        bit         wrap;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model of the scan: next LAB and the wraps it has produced.
    int m_idx   = 0;
    int m_wraps = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_host(input logic [7:0] w);
        exp_q.push_back('{word: w, gap: -1, wrap: 1'b0});
    endtask

    task automatic push_scan(input int gap);
        bit last;
        last = (m_idx == NUM_LAB - 1);
        exp_q.push_back('{word: 8'(m_idx), gap: gap, wrap: last});
        if (last) m_wraps++;
        m_idx = (m_idx + 1) % NUM_LAB;
    endtask

    // ---------------- monitor ----------------
    int         done_cnt = 0, start_cnt = 0, bit_cnt = 0, busy_len = 0;
    int         cyc = 0, last_start = -1, cur_gap = -1, wrap_seen = 0;
    logic [7:0] cap = '0;
    logic       cur_bit = 1'b0, prev_clk = 1'b0, prev_busy = 1'b0;
    bit         unstable = 1'b0, ready_in_busy = 1'b0;
    exp_t       e;

    initial begin
        forever begin
            @(negedge CLK);
            cyc++;
            if (!RST_N) begin
                prev_clk   = 1'b0;
                prev_busy  = 1'b0;
                last_start = -1;
                bit_cnt    = 0;
                continue;
            end
            if (scan_wrap_o === 1'b1) wrap_seen++;
            if (host_if.wr_ready_o && busy_o) ready_in_busy = 1'b1;
            if (busy_o && !prev_busy) begin
                cur_gap    = (last_start >= 0) ? cyc - last_start : -1;
                last_start = cyc;
                start_cnt++;
                bit_cnt  = 0;
                busy_len = 0;
                cap      = '0;
                unstable = 1'b0;
            end
            if (busy_o) busy_len++;
            if (CTRL_CLK && !prev_clk) begin
                if (bit_cnt < 8) cap[bit_cnt] = CTRL_DATA;
                cur_bit = CTRL_DATA;
                bit_cnt++;
            end else if (CTRL_CLK && (CTRL_DATA !== cur_bit)) begin
                unstable = 1'b1;
            end
            if (!busy_o && prev_busy) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got 0x%0h, expected no word at %0t", cap, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("word", cap, e.word);
                    check("bit_count", bit_cnt, 8);
                    check("busy_len", busy_len, BUSY_LEN);
                    check("cur_sel", cur_sel_o, e.word);
                    check("wrap_pulse", scan_wrap_o, e.wrap);
                    check("data_stable_high", unstable, 0);
                    if (e.gap >= 0) check("start_gap", cur_gap, e.gap);
                end
                done_cnt++;
            end
            prev_clk  = CTRL_CLK;
            prev_busy = busy_o;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic wait_done(input int n, input int budget);
        int k = 0;
        while (done_cnt < n && k < budget) begin tick(); k++; end
        check("wait_done_timeout", done_cnt >= n, 1);
    endtask

    task automatic wait_busy(input int budget);
        int k = 0;
        while (busy_o !== 1'b1 && k < budget) begin tick(); k++; end
        check("wait_busy_timeout", busy_o, 1);
    endtask

    task automatic wait_bits(input int n, input int budget);
        int k = 0;
        while (bit_cnt < n && k < budget) begin tick(); k++; end
        check("wait_bits_timeout", bit_cnt >= n, 1);
    endtask

    task automatic host_write(input logic [7:0] d, input int budget, output int waited);
        bit acc = 1'b0;
        waited = 0;
        host_if.wr_valid_i = 1'b1;
        host_if.wr_data_i  = d;
        while (!acc && waited < budget) begin
            #1;
            if (host_if.wr_ready_o) acc = 1'b1;
            @(posedge CLK);
            #2;
            waited++;
        end
        host_if.wr_valid_i = 1'b0;
        check("host_accept", acc, 1);
    endtask

    task automatic run_scan(input int n, input int dw);
        int base;
        base    = done_cnt;
        dwell_i = DWELL_W'(dw);
        for (int i = 0; i < n; i++) push_scan(i == 0 ? -1 : BASE_GAP + dw);
        scan_en_i = 1'b1;
        wait_done(base + n - 1, n * (BASE_GAP + dw) + 50);
        wait_busy(BASE_GAP + dw + 10);
        scan_en_i = 1'b0;
        wait_done(base + n, BASE_GAP + 10);
    endtask

    // ---------------- test sequence ----------------
    int k;
    int snap;

    initial begin
        host_if.wr_valid_i = 1'b0;
        host_if.wr_data_i  = '0;
        repeat (3) tick();
        check("rst_ctrl_clk", CTRL_CLK, 0);
        check("rst_ctrl_data", CTRL_DATA, 0);
        check("rst_busy", busy_o, 0);
        check("rst_cur_sel", cur_sel_o, 0);
        check("rst_wrap", scan_wrap_o, 0);
        check("rst_ready", host_if.wr_ready_o, 0);
        RST_N = 1'b1;
        repeat (2) tick();

        // Host write A5: bits 1,0,1,0,0,1,0,1 LSB first, shadow after 33 cycles.
        push_host(8'hA5);
        host_write(8'hA5, 20, k);
        wait_done(1, 100);

        // Scan with dwell 10: 00..0B, 00 (wrap on 0B), then on to LAB 5.
        dwell_i = DWELL_W'(10);
        for (int i = 0; i < 18; i++) push_scan(i == 0 ? -1 : BASE_GAP + 10);
        scan_en_i = 1'b1;
        wait_done(19, 19 * 60);

        // Host preempts the dwell after LAB 5; scan resumes at 06 with no dwell.
        check("in_dwell_before_preempt", busy_o, 0);
        push_host(8'h93);
        push_scan(BASE_GAP);
        push_scan(BASE_GAP + 10);
        host_write(8'h93, 20, k);
        check("dwell_abort_latency", k <= 3, 1);
        wait_done(21, 200);

        // Host request raised while scan word 07 is shifting.
        wait_busy(100);
        push_host(8'h20);
        push_scan(BASE_GAP);
        host_write(8'h20, 200, k);
        check("host_after_scan_word", done_cnt, 22);
        wait_done(23, 100);

        // Async reset after three bits of scan word 08.
        wait_busy(20);
        wait_bits(3, 40);
        RST_N     = 1'b0;
        scan_en_i = 1'b0;
        #1;
        exp_q.delete();
        m_idx = 0;
        check("midshift_rst_ctrl_clk", CTRL_CLK, 0);
        check("midshift_rst_ctrl_data", CTRL_DATA, 0);
        check("midshift_rst_busy", busy_o, 0);
        check("midshift_rst_cur_sel", cur_sel_o, 0);
        repeat (3) tick();
        RST_N = 1'b1;
        snap  = start_cnt;
        repeat (5) tick();
        check("idle_after_reset", busy_o, 0);
        check("no_start_after_reset", start_cnt, snap);

        // Scan from 00, drop enable while 07 shifts, then resume at 08 through a wrap.
        run_scan(8, $urandom_range(0, 15));
        snap = start_cnt;
        repeat (40) tick();
        check("no_scan_after_disable", start_cnt, snap);
        run_scan(5, $urandom_range(0, 15));

        // Randomised mix of host writes and scan bursts.
        for (int r = 0; r < 6; r++) begin
            if ($urandom_range(0, 1) == 1) begin
                logic [7:0] d;
                d    = 8'($urandom);
                snap = done_cnt;
                push_host(d);
                host_write(d, 20, k);
                wait_done(snap + 1, 100);
            end else begin
                run_scan($urandom_range(1, 6), $urandom_range(0, 15));
            end
        end

        repeat (5) tick();
        check("queue_drained", exp_q.size(), 0);
        check("wrap_total", wrap_seen, m_wraps);
        check("ready_during_busy", ready_in_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
